// File: rtl/rv_pipe_pkg.sv
// Types and constants shared by the RV32 fetch and decode stages.
package rv_pipe_pkg;

   localparam int unsigned RV_ADDR_W = 9;
   localparam int unsigned RV_XLEN   = 32;

   localparam logic [31:0] RV_NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] RV_EBREAK_INSTR = 32'h0010_0073;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'b00,
      FETCH_RUN  = 2'b01,
      FETCH_HALT = 2'b10
   } fetch_state_e;

   typedef struct packed {
      logic                 valid;
      logic [RV_ADDR_W-1:0] pc;
      logic [RV_ADDR_W-1:0] pc4;
      logic [RV_XLEN-1:0]   instr;
   } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load, otherwise contents stay.
module ifid_reg
   import rv_pipe_pkg::*;
#(
   parameter int unsigned      ADDR_W    = RV_ADDR_W,
   parameter int unsigned      XLEN      = RV_XLEN,
   parameter logic [XLEN-1:0]  NOP_INSTR = RV_NOP_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bubble_i,
   input  logic              hold_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [XLEN-1:0]   instr_i,
   output logic              valid_o,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc4_o,
   output logic [XLEN-1:0]   instr_o
);

   localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc4_q, pc4_d;
   logic [XLEN-1:0]   instr_q, instr_d;

   // A bubble keeps the pc fields so the squashed slot still carries a sane address.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      if (bubble_i) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end else if (load_i && !hold_i) begin
         valid_d = 1'b1;
         pc_d    = pc_i;
         pc4_d   = pc_i + PC_STEP;
         instr_d = instr_i;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_q <= 1'b0;
         pc_q    <= {ADDR_W{1'b0}};
         pc4_q   <= {ADDR_W{1'b0}};
         instr_q <= NOP_INSTR;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         pc4_q   <= pc4_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign pc4_o   = pc4_q;
   assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, IDLE/RUN/HALT run control and the IF/ID register.
// Build option IF_MISALIGN_TRAP_EN adds misalign_o and halts on a misaligned redirect.
module if_fetch_stage
   import rv_pipe_pkg::*;
#(
   parameter int unsigned       ADDR_W       = RV_ADDR_W,
   parameter int unsigned       XLEN         = RV_XLEN,
   parameter logic [ADDR_W-1:0] RESET_PC     = {ADDR_W{1'b0}},
   parameter logic [XLEN-1:0]   NOP_INSTR    = RV_NOP_INSTR,
   parameter logic [XLEN-1:0]   EBREAK_INSTR = RV_EBREAK_INSTR
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [XLEN-1:0]   imem_data_i,
   output logic              ifid_valid_o,
   output logic [ADDR_W-1:0] ifid_pc_o,
   output logic [ADDR_W-1:0] ifid_pc4_o,
   output logic [XLEN-1:0]   ifid_instr_o,
   output logic              halted_o
`ifdef IF_MISALIGN_TRAP_EN
   ,
   output logic              misalign_o
`endif
);

   localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;
   logic              in_run_s, trap_s, bubble_s, hold_s, load_s;

   assign in_run_s = (state_q == FETCH_RUN);

`ifdef IF_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
   assign trap_s = in_run_s & redirect_i & (redirect_pc_i[1:0] != 2'b00);
`else
   assign trap_s = 1'b0;
`endif

   assign bubble_s = (state_q == FETCH_IDLE) | (in_run_s & (flush_i | redirect_i));
   assign hold_s   = (state_q == FETCH_HALT) | (in_run_s & stall_i);
   assign load_s   = in_run_s & ~flush_i & ~redirect_i & ~stall_i;

   // Only a word actually captured into IF/ID can halt fetch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_IDLE: begin
            if (run_i) state_d = FETCH_RUN;
            else       state_d = FETCH_IDLE;
         end
         FETCH_RUN: begin
            if (trap_s || (load_s && (imem_data_i == EBREAK_INSTR))) state_d = FETCH_HALT;
            else                                                      state_d = FETCH_RUN;
         end
         FETCH_HALT: state_d = FETCH_HALT;
         default:    state_d = FETCH_IDLE;
      endcase
      halted_d = (state_d == FETCH_HALT);
   end

   always_comb begin
      pc_d = pc_q;
      if (!in_run_s) begin
         pc_d = pc_q;
      end else if (redirect_i) begin
         if (trap_s) pc_d = pc_q;
         else        pc_d = redirect_pc_i & ALIGN_MASK;
      end else if (stall_i) begin
         pc_d = pc_q;
      end else begin
         pc_d = pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= FETCH_IDLE;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

`ifdef IF_MISALIGN_TRAP_EN
   assign misalign_d = misalign_q | trap_s;

   always_ff @(posedge clk) begin
      if (!reset) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end

   assign misalign_o = misalign_q;
`endif

   ifid_reg #(
      .ADDR_W    (ADDR_W),
      .XLEN      (XLEN),
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk      (clk),
      .reset    (reset),
      .bubble_i (bubble_s),
      .hold_i   (hold_s),
      .load_i   (load_s),
      .pc_i     (pc_q),
      .instr_i  (imem_data_i),
      .valid_o  (ifid_valid_o),
      .pc_o     (ifid_pc_o),
      .pc4_o    (ifid_pc4_o),
      .instr_o  (ifid_instr_o)
   );

   assign imem_addr_o = pc_q;
   assign halted_o    = halted_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven scoreboard bench for if_fetch_stage (default build or IF_MISALIGN_TRAP_EN).
module tb_if_fetch_stage;

   localparam int NOP = 32'h0000_0013;
   localparam int EBR = 32'h0010_0073;

   typedef struct {
      logic        rst_n, run, stall, flush, redir;
      logic [8:0]  rpc;
      logic        valid;
      logic [8:0]  pc, pc4;
      logic [31:0] instr;
      logic [8:0]  addr;
      logic        halted, mis;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, run, stall, flush, redir;
   logic [8:0]  rpc;
   logic [8:0]  imem_addr;
   logic [31:0] imem_data;
   logic        ifid_valid;
   logic [8:0]  ifid_pc, ifid_pc4;
   logic [31:0] ifid_instr;
   logic        halted;
   logic        misalign;
   logic [31:0] mem [0:127];

   vec_t tbl[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   assign imem_data = mem[imem_addr[8:2]];

   if_fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .run_i         (run),
      .stall_i       (stall),
      .flush_i       (flush),
      .redirect_i    (redir),
      .redirect_pc_i (rpc),
      .imem_addr_o   (imem_addr),
      .imem_data_i   (imem_data),
      .ifid_valid_o  (ifid_valid),
      .ifid_pc_o     (ifid_pc),
      .ifid_pc4_o    (ifid_pc4),
      .ifid_instr_o  (ifid_instr),
      .halted_o      (halted)
`ifdef IF_MISALIGN_TRAP_EN
      ,
      .misalign_o    (misalign)
`endif
   );

`ifndef IF_MISALIGN_TRAP_EN
   assign misalign = 1'b0;
`endif

   function automatic vec_t mk(input int r, input int rn, input int st, input int fl,
                               input int rd, input int rp, input int v, input int pc,
                               input int pc4, input int ins, input int ad, input int h,
                               input int m);
      vec_t x;
      x.rst_n = r[0];   x.run = rn[0];   x.stall = st[0]; x.flush = fl[0];
      x.redir = rd[0];  x.rpc = rp[8:0]; x.valid = v[0];  x.pc = pc[8:0];
      x.pc4 = pc4[8:0]; x.instr = ins;   x.addr = ad[8:0];
      x.halted = h[0];  x.mis = m[0];
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      reset = v.rst_n; run = v.run; stall = v.stall; flush = v.flush;
      redir = v.redir; rpc = v.rpc;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".valid"},  {31'd0, ifid_valid}, {31'd0, e.valid});
      chk({tag, ".pc"},     {23'd0, ifid_pc},    {23'd0, e.pc});
      chk({tag, ".pc4"},    {23'd0, ifid_pc4},   {23'd0, e.pc4});
      chk({tag, ".instr"},  ifid_instr,          e.instr);
      chk({tag, ".addr"},   {23'd0, imem_addr},  {23'd0, e.addr});
      chk({tag, ".halted"}, {31'd0, halted},     {31'd0, e.halted});
`ifdef IF_MISALIGN_TRAP_EN
      chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e.mis});
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h00A0_0000 | i;
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
      reset = 1'b0; run = 1'b0; stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = 9'd0;

      //           r rn st fl rd rpc     v pc     pc4    instr      addr   h m
      tbl.push_back(mk(0,0,0,0,0,0,      0,0,     0,     NOP,       0,     0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      0,0,     0,     NOP,       0,     0,0));
      tbl.push_back(mk(1,1,0,0,0,0,      0,0,     0,     NOP,       0,     0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,0,     4,     'h11,      4,     0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,4,     8,     'h22,      8,     0,0));
      tbl.push_back(mk(1,0,1,0,0,0,      1,4,     8,     'h22,      8,     0,0));
      tbl.push_back(mk(1,0,1,0,0,0,      1,4,     8,     'h22,      8,     0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,8,     'hC,   'h33,      'hC,   0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,'hC,   'h10,  'hA00003,  'h10,  0,0));
      tbl.push_back(mk(1,0,0,1,1,'h40,   0,'hC,   'h10,  NOP,       'h40,  0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,'h40,  'h44,  'hA00010,  'h44,  0,0));
      tbl.push_back(mk(1,0,1,1,1,'h40,   0,'h40,  'h44,  NOP,       'h40,  0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,'h40,  'h44,  'hA00010,  'h44,  0,0));
      tbl.push_back(mk(1,0,0,1,1,'h1FC,  0,'h40,  'h44,  NOP,       'h1FC, 0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,'h1FC, 0,     'hA0007F,  0,     0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,0,     4,     'h11,      4,     0,0));
`ifdef IF_MISALIGN_TRAP_EN
      tbl.push_back(mk(1,0,0,0,1,'h42,   0,0,     4,     NOP,       4,     1,1));
      tbl.push_back(mk(1,0,0,0,0,0,      0,0,     4,     NOP,       4,     1,1));
`else
      tbl.push_back(mk(1,0,0,0,1,'h42,   0,0,     4,     NOP,       'h40,  0,0));
      tbl.push_back(mk(1,0,0,0,0,0,      1,'h40,  'h44,  'hA00010,  'h44,  0,0));
`endif
      tbl.push_back(mk(0,0,0,0,0,0,      0,0,     0,     NOP,       0,     0,0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));

      // EBREAK at 0x0C halts; HALT then ignores stall/flush/redirect
      mem[3] = EBR;
      apply(mk(1,1,0,0,0,0,      0,0,    0,    NOP,  0,    0,0), "ebr_run");
      apply(mk(1,0,0,0,0,0,      1,0,    4,    'h11, 4,    0,0), "ebr_i0");
      apply(mk(1,0,0,0,0,0,      1,4,    8,    'h22, 8,    0,0), "ebr_i1");
      apply(mk(1,0,0,0,0,0,      1,8,    'hC,  'h33, 'hC,  0,0), "ebr_i2");
      apply(mk(1,0,0,0,0,0,      1,'hC,  'h10, EBR,  'h10, 1,0), "ebr_cap");
      apply(mk(1,0,1,1,1,'h80,   1,'hC,  'h10, EBR,  'h10, 1,0), "ebr_frozen");
      apply(mk(1,0,0,0,0,0,      1,'hC,  'h10, EBR,  'h10, 1,0), "ebr_stay");
      apply(mk(0,0,0,0,0,0,      0,0,    0,    NOP,  0,    0,0), "ebr_reset");

      // A flushed EBREAK must not halt
      apply(mk(1,1,0,0,0,0,      0,0,    0,    NOP,      0,    0,0), "fl_run");
      apply(mk(1,0,0,0,0,0,      1,0,    4,    'h11,     4,    0,0), "fl_i0");
      apply(mk(1,0,0,0,0,0,      1,4,    8,    'h22,     8,    0,0), "fl_i1");
      apply(mk(1,0,0,0,0,0,      1,8,    'hC,  'h33,     'hC,  0,0), "fl_i2");
      apply(mk(1,0,0,1,0,0,      0,8,    'hC,  NOP,      'h10, 0,0), "fl_ebr");
      apply(mk(1,0,0,0,0,0,      1,'h10, 'h14, 'hA00004, 'h14, 0,0), "fl_next");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
